// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and the standard
// Fibonacci tap masks. Bit i of a mask selects stream bit b[n-1-i].
package prbs_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // x^7 + x^6 + 1
  localparam logic [6:0]  PRBS7  = 7'h60;
  // x^15 + x^14 + 1
  localparam logic [14:0] PRBS15 = 15'h6000;
  // x^31 + x^28 + 1
  localparam logic [30:0] PRBS31 = 31'h48000000;

endpackage

// File: rtl/lfsr_prbs_checker_sat_cnt.sv
// sat_cnt: up-counter that sticks at all-ones. A clear wins over the old
// value but not over an increment arriving in the same cycle, so the
// result of clear-plus-increment is 1.
module sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: self-synchronising serial PRBS checker.
// SEARCH fills the shift register from the line, VERIFY keeps loading line
// bits while counting correct predictions, LOCKED free-runs on its own
// predictions so one line error produces exactly one flagged bit.
// Optional feature macro: PRBS_CHK_ERR_CNT_EN builds the saturating error
// counter and honours clr_i; without it err_cnt_o is tied to zero.
module lfsr_prbs_checker
  import prbs_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 7,
  parameter logic [DATA_WIDTH-1:0] POLY          = DATA_WIDTH'(PRBS7),
  parameter int                    LOCK_CNT      = 16,
  parameter int                    UNLOCK_THR    = 4,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     vld_i,
  input  logic                     bit_i,
  input  logic                     clr_i,
  output logic                     lock_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

  // Run counters only need to reach (limit - 1); the limit itself is the
  // transition condition.
  localparam int FILL_W  = $clog2(DATA_WIDTH);
  localparam int MATCH_W = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
  localparam int MISS_W  = (UNLOCK_THR > 1) ? $clog2(UNLOCK_THR) : 1;

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(DATA_WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_THR - 1);

  chk_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [MATCH_W-1:0]    match_q, match_d;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic                  lock_q, lock_d;
  logic                  err_q, err_d;

  logic                  pred;
  logic [DATA_WIDTH-1:0] s_line;
  logic [DATA_WIDTH-1:0] s_free;

  assign pred   = ^(s_q & POLY);
  assign s_line = {s_q[DATA_WIDTH-2:0], bit_i};
  assign s_free = {s_q[DATA_WIDTH-2:0], pred};

  // Next-state, shift-register and run-counter logic; idle cycles hold all.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    lock_d  = lock_q;
    err_d   = 1'b0;

    if (vld_i) begin
      case (state_q)
        SEARCH: begin
          s_d = s_line;
          if (fill_q == FILL_LAST) begin
            // A full register of zeros is the LFSR lock-up state: refill.
            fill_d = '0;
            if (s_line != '0) begin
              state_d = VERIFY;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        VERIFY: begin
          s_d = s_line;
          if (bit_i == pred) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              match_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            state_d = SEARCH;
            fill_d  = '0;
            match_d = '0;
          end
        end

        LOCKED: begin
          s_d = s_free;
          if (bit_i != pred) begin
            err_d = 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d = SEARCH;
              lock_d  = 1'b0;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d = SEARCH;
          lock_d  = 1'b0;
          fill_d  = '0;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // State, shift register, run counters and registered flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SEARCH;
      s_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign lock_o = lock_q;
  assign err_o  = err_q;

`ifdef PRBS_CHK_ERR_CNT_EN
  sat_cnt #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .inc_i   (err_d),
    .cnt_o   (err_cnt_o)
  );
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker with a PRBS7 stream source.
// Expected error counts follow PRBS_CHK_ERR_CNT_EN (zero when not built).
module tb_lfsr_prbs_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld;
  logic       bit_in;
  logic       clr;
  logic       lock;
  logic       err;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;

`ifdef PRBS_CHK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // PRBS7 source state, x^7 + x^6 + 1
  logic [6:0] gen;

  lfsr_prbs_checker #(
    .DATA_WIDTH    (7),
    .POLY          (7'h60),
    .LOCK_CNT      (16),
    .UNLOCK_THR    (4),
    .ERR_CNT_WIDTH (4)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .vld_i     (vld),
    .bit_i     (bit_in),
    .clr_i     (clr),
    .lock_o    (lock),
    .err_o     (err),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] exp_cnt(input int n);
    if (!CNT_EN) return 4'd0;
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic next_prbs(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  // Drive one cycle at the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    vld    = v;
    bit_in = b;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_good(input int n, output int pulses, output int unlocked);
    logic b;
    pulses   = 0;
    unlocked = 0;
    for (int i = 0; i < n; i++) begin
      next_prbs(b);
      step(1'b1, b, 1'b0);
      if (err !== 1'b0) pulses++;
      if (lock !== 1'b1) unlocked++;
    end
  endtask

  task automatic do_reset(input logic [6:0] seed);
    @(negedge clk);
    rst_n = 1'b0;
    vld = 1'b0; bit_in = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    gen = seed;
  endtask

  // Feed 23 clean bits; lock must be low after 22 and high after 23.
  task automatic lock_from_reset(input string tag);
    logic b;
    for (int i = 1; i <= 23; i++) begin
      next_prbs(b);
      step(1'b1, b, 1'b0);
      if (i == 22) begin
        checks++;
        if (lock !== 1'b0) begin
          errors++; $display("FAIL %s_lock_early: lock=%0b expected 0 after 22 bits", tag, lock);
        end
      end
    end
    checks++;
    if (lock !== 1'b1) begin
      errors++; $display("FAIL %s_lock_23: lock=%0b expected 1 after 23 bits", tag, lock);
    end
  endtask

  task automatic test_reset();
    logic b;
    do_reset(7'h01);
    checks++;
    if (lock !== 1'b0 || err !== 1'b0 || err_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_values: lock=%0b err=%0b cnt=%0d expected 0/0/0", lock, err, err_cnt);
    end
    lock_from_reset("reset_first");
    // one error so err_o and err_cnt_o are non-zero, then reset asynchronously
    next_prbs(b);
    step(1'b1, ~b, 1'b0);
    checks++;
    if (err !== 1'b1 || err_cnt !== exp_cnt(1)) begin
      errors++; $display("FAIL reset_pre_err: err=%0b cnt=%0d expected 1/%0d", err, err_cnt, exp_cnt(1));
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lock !== 1'b0 || err !== 1'b0 || err_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_async: lock=%0b err=%0b cnt=%0d expected 0/0/0", lock, err, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    gen = 7'h35;
    // partial progress (into VERIFY), then reset again
    for (int i = 0; i < 15; i++) begin
      next_prbs(b);
      step(1'b1, b, 1'b0);
    end
    do_reset(7'h5A);
    lock_from_reset("reset_relock");
  endtask

  task automatic test_clean_lock();
    int pulses, unlocked;
    do_reset(7'h7F);
    lock_from_reset("clean");
    send_good(1000, pulses, unlocked);
    checks++;
    if (pulses != 0 || unlocked != 0) begin
      errors++; $display("FAIL clean_run: err_pulses=%0d unlocked_cycles=%0d expected 0/0", pulses, unlocked);
    end
    checks++;
    if (err_cnt !== 4'd0) begin
      errors++; $display("FAIL clean_cnt: cnt=%0d expected 0", err_cnt);
    end
  endtask

  task automatic test_single_error();
    logic b;
    int pulses, unlocked;
    next_prbs(b);
    step(1'b1, b, 1'b1);
    next_prbs(b);
    step(1'b1, ~b, 1'b0);
    checks++;
    if (err !== 1'b1 || err_cnt !== exp_cnt(1) || lock !== 1'b1) begin
      errors++; $display("FAIL single_err: err=%0b cnt=%0d lock=%0b expected 1/%0d/1", err, err_cnt, lock, exp_cnt(1));
    end
    next_prbs(b);
    step(1'b1, b, 1'b0);
    checks++;
    if (err !== 1'b0 || err_cnt !== exp_cnt(1) || lock !== 1'b1) begin
      errors++; $display("FAIL single_after: err=%0b cnt=%0d lock=%0b expected 0/%0d/1", err, err_cnt, lock, exp_cnt(1));
    end
    send_good(50, pulses, unlocked);
    checks++;
    if (pulses != 0 || unlocked != 0 || err_cnt !== exp_cnt(1)) begin
      errors++; $display("FAIL single_tail: pulses=%0d unlocked=%0d cnt=%0d expected 0/0/%0d", pulses, unlocked, err_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_saturation();
    logic b;
    int pulses, unlocked, tot;
    tot = 0;
    next_prbs(b);
    step(1'b1, b, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send_good(3, pulses, unlocked);
      next_prbs(b);
      step(1'b1, ~b, 1'b0);
      if (err === 1'b1) tot++;
    end
    checks++;
    if (tot != 20) begin
      errors++; $display("FAIL sat_pulses: pulses=%0d expected 20", tot);
    end
    checks++;
    if (err_cnt !== exp_cnt(20) || lock !== 1'b1) begin
      errors++; $display("FAIL sat_value: cnt=%0d lock=%0b expected %0d/1", err_cnt, lock, exp_cnt(20));
    end
    next_prbs(b);
    step(1'b1, ~b, 1'b1);
    checks++;
    if (err_cnt !== exp_cnt(1) || err !== 1'b1) begin
      errors++; $display("FAIL sat_clr_err: cnt=%0d err=%0b expected %0d/1", err_cnt, err, exp_cnt(1));
    end
  endtask

  task automatic test_loss_of_lock();
    logic b;
    logic [6:0] look;
    logic [3:0] ahead;
    int guard, pulses, relocks;
    next_prbs(b);
    step(1'b1, b, 1'b1);
    // advance until the next four stream bits are all ones
    guard = 0;
    forever begin
      look = gen;
      for (int k = 0; k < 4; k++) begin
        ahead[k] = look[6] ^ look[5];
        look = {look[5:0], ahead[k]};
      end
      if (ahead == 4'hF || guard > 200) break;
      next_prbs(b);
      step(1'b1, b, 1'b0);
      guard++;
    end
    checks++;
    if (guard > 200) begin
      errors++; $display("FAIL lol_align: guard=%0d expected <=200", guard);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (err !== 1'b1 || lock !== (i < 4)) begin
        errors++; $display("FAIL lol_miss%0d: err=%0b lock=%0b expected 1/%0b", i, err, lock, (i < 4));
      end
    end
    checks++;
    if (err_cnt !== exp_cnt(4)) begin
      errors++; $display("FAIL lol_cnt: cnt=%0d expected %0d", err_cnt, exp_cnt(4));
    end
    pulses = 0; relocks = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (err !== 1'b0) pulses++;
      if (lock !== 1'b0) relocks++;
    end
    checks++;
    if (pulses != 0 || relocks != 0 || err_cnt !== exp_cnt(4)) begin
      errors++; $display("FAIL lol_zeros: pulses=%0d lock_cycles=%0d cnt=%0d expected 0/0/%0d", pulses, relocks, err_cnt, exp_cnt(4));
    end
  endtask

  task automatic test_valid_gaps();
    logic b, lock_prev;
    int accepted, cycles, pulses, idle_bad;
    do_reset(7'h4B);
    accepted = 0; cycles = 0; pulses = 0; idle_bad = 0;
    while (accepted < 323 && cycles < 5000) begin
      cycles++;
      if ($urandom_range(0, 99) < 30) begin
        next_prbs(b);
        step(1'b1, b, 1'b0);
        accepted++;
        if (err !== 1'b0) pulses++;
        if (accepted == 22) begin
          checks++;
          if (lock !== 1'b0) begin
            errors++; $display("FAIL gaps_lock_early: lock=%0b expected 0 after 22 accepted", lock);
          end
        end
        if (accepted == 23) begin
          checks++;
          if (lock !== 1'b1) begin
            errors++; $display("FAIL gaps_lock_23: lock=%0b expected 1 after 23 accepted", lock);
          end
        end
      end else begin
        lock_prev = lock;
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (lock !== lock_prev || err !== 1'b0) idle_bad++;
      end
    end
    checks++;
    if (accepted != 323) begin
      errors++; $display("FAIL gaps_budget: accepted=%0d expected 323", accepted);
    end
    checks++;
    if (pulses != 0 || idle_bad != 0 || lock !== 1'b1 || err_cnt !== 4'd0) begin
      errors++; $display("FAIL gaps_run: pulses=%0d idle_changes=%0d lock=%0b cnt=%0d expected 0/0/1/0", pulses, idle_bad, lock, err_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; bit_in = 1'b0; clr = 1'b0;
    gen = 7'h01;
    #12;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_saturation();
    test_loss_of_lock();
    test_valid_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
